gx_reset_ctrl: RTL and testbench

- Transceiver reset sequencer that sits between the PCS top and the Cyclone 10 GX native PHY channel.
- Drives the tx/rx analogreset and digitalreset pins in the order the PHY requires.
- Gates those releases on calibration completion, TX PLL lock and CDR lock-to-data.
- Reports tx_ready_o / rx_ready_o, which the PCS uses to release its own par-clock-domain resets.
- Runs in the 50 MHz free-running clock domain. One instance per serdes channel.

---
 rtl/gx_reset_ctrl.sv | 149 ++++++++++++++
 tb/tb_gx_reset_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gx_reset_ctrl.sv
// Transceiver reset sequencer for one native PHY channel: orders analog/digital reset release
// on calibration, TX PLL lock and CDR lock-to-data, and reports per-direction readiness.
module gx_reset_ctrl #(
    parameter int unsigned ANALOG_CYC  = 4,
    parameter int unsigned DIGITAL_CYC = 3,
    parameter int unsigned LTD_CYC     = 200,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic nreset,
    input  logic restart_i,
    input  logic pll_locked_i,
    input  logic tx_cal_busy_i,
    input  logic rx_cal_busy_i,
    input  logic rx_is_lockedtodata_i,
    output logic tx_analogreset_o,
    output logic tx_digitalreset_o,
    output logic rx_analogreset_o,
    output logic rx_digitalreset_o,
    output logic tx_ready_o,
    output logic rx_ready_o
);

    typedef enum logic [1:0] {TxRst, TxWait, TxDig, TxReady} tx_state_e;
    typedef enum logic [1:0] {RxRst, RxWait, RxLock, RxReady} rx_state_e;

    localparam logic [CNT_W-1:0] AnalogLast  = CNT_W'(ANALOG_CYC - 1);
    localparam logic [CNT_W-1:0] DigitalLast = CNT_W'(DIGITAL_CYC - 1);
    localparam logic [CNT_W-1:0] LtdLast     = CNT_W'(LTD_CYC - 1);

    // Bit order {lockedtodata, pll_locked, rx_cal_busy, tx_cal_busy}; resets to the safe values.
    localparam logic [3:0] SyncRst = 4'b0011;

    logic [3:0] sync_meta_q, sync_q;
    logic       tx_cal_busy_s, rx_cal_busy_s, pll_locked_s, lockedtodata_s;

    tx_state_e        tx_state_q, tx_state_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic             tx_analog_d, tx_digital_d, tx_ready_d;
    logic             rx_analog_d, rx_digital_d, rx_ready_d;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_meta_q <= SyncRst;
            sync_q      <= SyncRst;
        end else begin
            sync_meta_q <= {rx_is_lockedtodata_i, pll_locked_i, rx_cal_busy_i, tx_cal_busy_i};
            sync_q      <= sync_meta_q;
        end
    end

    assign tx_cal_busy_s  = sync_q[0];
    assign rx_cal_busy_s  = sync_q[1];
    assign pll_locked_s   = sync_q[2];
    assign lockedtodata_s = sync_q[3];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            TxRst: begin
                if (tx_cnt_q == AnalogLast) tx_state_d = TxWait;
                else                        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
            end
            TxWait: begin
                if (pll_locked_s && !tx_cal_busy_s) tx_state_d = TxDig;
            end
            TxDig: begin
                if (!pll_locked_s)                tx_state_d = TxWait;
                else if (tx_cnt_q == DigitalLast) tx_state_d = TxReady;
                else                              tx_cnt_d   = tx_cnt_q + CNT_W'(1);
            end
            TxReady: begin
                if (!pll_locked_s || tx_cal_busy_s) tx_state_d = TxRst;
            end
            default: tx_state_d = TxRst;
        endcase
        if (tx_state_d != tx_state_q) tx_cnt_d = '0;
        if (restart_i) begin
            tx_state_d = TxRst;
            tx_cnt_d   = '0;
        end
        // Outputs decode the next state so the registered pins track the state register.
        tx_analog_d  = (tx_state_d == TxRst);
        tx_digital_d = (tx_state_d != TxReady);
        tx_ready_d   = (tx_state_d == TxReady);
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        case (rx_state_q)
            RxRst: begin
                if (rx_cnt_q == AnalogLast) rx_state_d = RxWait;
                else                        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
            end
            RxWait: begin
                if (!rx_cal_busy_s) rx_state_d = RxLock;
            end
            RxLock: begin
                if (rx_cal_busy_s)            rx_state_d = RxRst;
                else if (!lockedtodata_s)     rx_cnt_d   = '0;
                else if (rx_cnt_q == LtdLast) rx_state_d = RxReady;
                else                          rx_cnt_d   = rx_cnt_q + CNT_W'(1);
            end
            RxReady: begin
                if (rx_cal_busy_s)        rx_state_d = RxRst;
                else if (!lockedtodata_s) rx_state_d = RxLock;
            end
            default: rx_state_d = RxRst;
        endcase
        if (rx_state_d != rx_state_q) rx_cnt_d = '0;
        if (restart_i) begin
            rx_state_d = RxRst;
            rx_cnt_d   = '0;
        end
        rx_analog_d  = (rx_state_d == RxRst);
        rx_digital_d = (rx_state_d != RxReady);
        rx_ready_d   = (rx_state_d == RxReady);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx_state_q        <= TxRst;
            rx_state_q        <= RxRst;
            tx_cnt_q          <= '0;
            rx_cnt_q          <= '0;
            tx_analogreset_o  <= 1'b1;
            tx_digitalreset_o <= 1'b1;
            tx_ready_o        <= 1'b0;
            rx_analogreset_o  <= 1'b1;
            rx_digitalreset_o <= 1'b1;
            rx_ready_o        <= 1'b0;
        end else begin
            tx_state_q        <= tx_state_d;
            rx_state_q        <= rx_state_d;
            tx_cnt_q          <= tx_cnt_d;
            rx_cnt_q          <= rx_cnt_d;
            tx_analogreset_o  <= tx_analog_d;
            tx_digitalreset_o <= tx_digital_d;
            tx_ready_o        <= tx_ready_d;
            rx_analogreset_o  <= rx_analog_d;
            rx_digitalreset_o <= rx_digital_d;
            rx_ready_o        <= rx_ready_d;
        end
    end

endmodule

// File: tb/tb_gx_reset_ctrl.sv
// Directed bench for gx_reset_ctrl: cycle-indexed stimulus with hand-computed pin values,
// cycle 0 being the instant nreset is released.
module tb_gx_reset_ctrl;

    logic clk = 1'b0;
    logic nreset, restart, pll, txb, rxb, ltd;
    logic tx_ana, tx_dig, rx_ana, rx_dig, tx_rdy, rx_rdy;
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    gx_reset_ctrl #(
        .ANALOG_CYC (4),
        .DIGITAL_CYC(3),
        .LTD_CYC    (8),
        .CNT_W      (8)
    ) dut (
        .clk                 (clk),
        .nreset              (nreset),
        .restart_i           (restart),
        .pll_locked_i        (pll),
        .tx_cal_busy_i       (txb),
        .rx_cal_busy_i       (rxb),
        .rx_is_lockedtodata_i(ltd),
        .tx_analogreset_o    (tx_ana),
        .tx_digitalreset_o   (tx_dig),
        .rx_analogreset_o    (rx_ana),
        .rx_digitalreset_o   (rx_dig),
        .tx_ready_o          (tx_rdy),
        .rx_ready_o          (rx_rdy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_tx_ana"}, tx_ana, 1'b1);
        chk({tag, "_tx_dig"}, tx_dig, 1'b1);
        chk({tag, "_rx_ana"}, rx_ana, 1'b1);
        chk({tag, "_rx_dig"}, rx_dig, 1'b1);
        chk({tag, "_tx_rdy"}, tx_rdy, 1'b0);
        chk({tag, "_rx_rdy"}, rx_rdy, 1'b0);
    endtask

    initial begin
        nreset = 1'b0; restart = 1'b0;
        pll = 1'b1; txb = 1'b0; rxb = 1'b0; ltd = 1'b1;
        cyc = 0;
        repeat (3) tick();
        chk_all_reset("por");

        // Power-up with all conditions good
        nreset = 1'b1; cyc = 0;
        wait_to(3);  chk("pu_tx_ana_hold", tx_ana, 1'b1); chk("pu_rx_ana_hold", rx_ana, 1'b1);
        wait_to(4);  chk("pu_tx_ana_rel", tx_ana, 1'b0); chk("pu_rx_ana_rel", rx_ana, 1'b0);
                     chk("pu_tx_dig_wait", tx_dig, 1'b1);
        wait_to(7);  chk("pu_tx_dig_hold", tx_dig, 1'b1); chk("pu_tx_rdy_lo", tx_rdy, 1'b0);
        wait_to(8);  chk("pu_tx_dig_rel", tx_dig, 1'b0); chk("pu_tx_rdy_hi", tx_rdy, 1'b1);
        wait_to(12); chk("pu_rx_rdy_lo", rx_rdy, 1'b0); chk("pu_rx_dig_hold", rx_dig, 1'b1);
        wait_to(13); chk("pu_rx_rdy_hi", rx_rdy, 1'b1); chk("pu_rx_dig_rel", rx_dig, 1'b0);

        // Loss of CDR lock in RX ready, then regain
        wait_to(15); ltd = 1'b0;
        wait_to(17); chk("lol_rx_rdy_still", rx_rdy, 1'b1);
        wait_to(18); chk("lol_rx_rdy_lo", rx_rdy, 1'b0); chk("lol_rx_dig", rx_dig, 1'b1);
                     chk("lol_rx_ana", rx_ana, 1'b0);
                     ltd = 1'b1;
        wait_to(27); chk("relock_rx_rdy_lo", rx_rdy, 1'b0);
        wait_to(28); chk("relock_rx_rdy_hi", rx_rdy, 1'b1);

        // TX PLL loss in TX ready
        wait_to(30); pll = 1'b0;
        wait_to(32); chk("pll_tx_rdy_still", tx_rdy, 1'b1);
        wait_to(33); chk("pll_tx_ana", tx_ana, 1'b1); chk("pll_tx_rdy_lo", tx_rdy, 1'b0);
                     chk("pll_tx_dig", tx_dig, 1'b1);
                     pll = 1'b1;
        wait_to(36); chk("pll_tx_ana_hold", tx_ana, 1'b1);
        wait_to(37); chk("pll_tx_ana_rel", tx_ana, 1'b0);
        wait_to(40); chk("pll_tx_rdy_lo2", tx_rdy, 1'b0);
        wait_to(41); chk("pll_tx_rdy_hi", tx_rdy, 1'b1); chk("pll_rx_indep", rx_rdy, 1'b1);

        // restart coincides with an RX loss of lock
        wait_to(45); ltd = 1'b0;
        wait_to(47); chk("rs_rx_rdy_pre", rx_rdy, 1'b1); restart = 1'b1;
        wait_to(48); chk_all_reset("restart");
                     restart = 1'b0; ltd = 1'b1;
        wait_to(55); chk("rs_tx_rdy_lo", tx_rdy, 1'b0);
        wait_to(56); chk("rs_tx_rdy_hi", tx_rdy, 1'b1);

        // Asynchronous reset mid-operation
        nreset = 1'b0;
        #1;
        chk_all_reset("async");

        // Calibration gating, with an RX lock glitch at count 6
        txb = 1'b1;
        repeat (2) tick();
        nreset = 1'b1; cyc = 0;
        wait_to(9);  ltd = 1'b0;
        wait_to(10); ltd = 1'b1;
        wait_to(13); chk("glitch_rx_rdy_13", rx_rdy, 1'b0);
        wait_to(19); chk("glitch_rx_rdy_19", rx_rdy, 1'b0); chk("glitch_rx_dig", rx_dig, 1'b1);
        wait_to(20); chk("glitch_rx_rdy_20", rx_rdy, 1'b1); chk("glitch_rx_dig_rel", rx_dig, 1'b0);
        wait_to(54); chk("cal_tx_dig", tx_dig, 1'b1); chk("cal_tx_ana", tx_ana, 1'b0);
                     chk("cal_tx_rdy", tx_rdy, 1'b0);
                     txb = 1'b0;
        wait_to(59); chk("cal_tx_rdy_lo", tx_rdy, 1'b0);
        wait_to(60); chk("cal_tx_rdy_hi", tx_rdy, 1'b1); chk("cal_tx_dig_rel", tx_dig, 1'b0);

        // cal_busy and loss of lock together: RST wins over LOCK
        wait_to(62); rxb = 1'b1; ltd = 1'b0;
        wait_to(64); chk("prio_rx_rdy_pre", rx_rdy, 1'b1); chk("prio_rx_ana_pre", rx_ana, 1'b0);
        wait_to(65); chk("prio_rx_ana", rx_ana, 1'b1); chk("prio_rx_rdy", rx_rdy, 1'b0);
                     chk("prio_rx_dig", rx_dig, 1'b1); chk("prio_tx_indep", tx_rdy, 1'b1);

        // TX calibration restarting in TX ready
        wait_to(66); txb = 1'b1;
        wait_to(68); chk("txcal_rdy_pre", tx_rdy, 1'b1);
        wait_to(69); chk("txcal_tx_ana", tx_ana, 1'b1); chk("txcal_tx_rdy", tx_rdy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
